// File: rtl/avg_nearest_win_if.sv
// avg_nearest_win_if: sample-in / result-out bundle for the nearest-to-mean
// window filter. The master is the sample source and result consumer; the
// slave is the filter itself.
interface avg_nearest_win_if #(
    parameter int DW = 16
);
    logic          din_valid;
    logic [DW-1:0] din;
    logic          din_ready;
    logic          ready;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic [DW-1:0] avg_out;

    modport master (
        output din_valid, din,
        input  din_ready, ready, dout_valid, dout, avg_out
    );

    modport slave (
        input  din_valid, din,
        output din_ready, ready, dout_valid, dout, avg_out
    );
endinterface

// File: rtl/avg_nearest_win.sv
// avg_nearest_win: sliding-window filter that keeps the last DEPTH samples,
// computes their integer mean with a bit-serial restoring divider and then
// scans the window for the sample closest to that mean (ties -> lower value).
// Build option: define AVG_ROUND_EN to round the mean half-up instead of
// truncating it; latency is the same either way.
module avg_nearest_win #(
    parameter int DW    = 16,
    parameter int DEPTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    avg_nearest_win_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);       // buffer index / remainder width
    localparam int SW  = DW + $clog2(DEPTH);  // running-sum width
    localparam int CW  = $clog2(DEPTH + 1);   // sample counter width
    localparam int DCW = $clog2(SW + 1);      // divider step counter width

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]     state_r;
    logic [DW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic [SW-1:0]  sum_r;
    logic           ready_r;
    logic [SW-1:0]  quo_r;        // dividend shifts out, quotient shifts in
    logic [AW-1:0]  rem_r;
    logic [DCW-1:0] div_cnt_r;
    logic [AW-1:0]  scan_idx_r;
    logic [DW-1:0]  best_val_r;
    logic [DW-1:0]  best_dist_r;
    logic [DW-1:0]  dout_r;
    logic [DW-1:0]  avg_r;
    logic           dout_valid_r;

    logic           accept_s;
    logic           full_s;
    logic [DW-1:0]  oldest_s;
    logic [SW-1:0]  sum_next_s;
    logic [SW-1:0]  div_in_s;
    logic [AW:0]    rem_shift_s;
    logic [AW-1:0]  rem_next_s;
    logic           qbit_s;
    logic [DW-1:0]  avg_s;
    logic [DW-1:0]  cur_s;
    logic [DW-1:0]  dist_s;
    logic           take_s;
    logic [DW-1:0]  new_best_val_s;
    logic [DW-1:0]  new_best_dist_s;

    assign accept_s = bus.din_valid && (state_r == ST_IDLE);
    assign full_s   = (count_r == CW'(DEPTH));
    assign avg_s    = quo_r[DW-1:0];
    assign cur_s    = mem_r[scan_idx_r];

    // Sum update: once the window is full the entry at wr_ptr is the oldest
    // sample and is retired in the same cycle the new one is added.
    always_comb begin
        oldest_s   = full_s ? mem_r[wr_ptr_r] : {DW{1'b0}};
        sum_next_s = sum_r - SW'(oldest_s) + SW'(bus.din);
        div_in_s   = sum_next_s;
`ifdef AVG_ROUND_EN
        div_in_s   = sum_next_s + SW'(DEPTH / 2);
`endif
    end

    // One restoring-division step: bring down the next dividend bit and
    // subtract DEPTH when it fits.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[SW-1]};
        if (rem_shift_s >= (AW+1)'(DEPTH)) begin
            rem_next_s = AW'(rem_shift_s - (AW+1)'(DEPTH));
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = rem_shift_s[AW-1:0];
            qbit_s     = 1'b0;
        end
    end

    // Scan compare: first entry always seeds the best; afterwards strictly
    // closer wins and equal distance prefers the smaller sample.
    always_comb begin
        if (cur_s >= avg_s) begin
            dist_s = cur_s - avg_s;
        end else begin
            dist_s = avg_s - cur_s;
        end
        take_s = (scan_idx_r == AW'(0)) || (dist_s < best_dist_r) ||
                 ((dist_s == best_dist_r) && (cur_s < best_val_r));
        if (take_s) begin
            new_best_val_s  = cur_s;
            new_best_dist_s = dist_s;
        end else begin
            new_best_val_s  = best_val_r;
            new_best_dist_s = best_dist_r;
        end
    end

    // Window storage; contents are never read before being written.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= bus.din;
        end
    end

    // Control FSM with fill bookkeeping, divider and scan datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            sum_r        <= {SW{1'b0}};
            ready_r      <= 1'b0;
            quo_r        <= {SW{1'b0}};
            rem_r        <= {AW{1'b0}};
            div_cnt_r    <= {DCW{1'b0}};
            scan_idx_r   <= {AW{1'b0}};
            best_val_r   <= {DW{1'b0}};
            best_dist_r  <= {DW{1'b1}};
            dout_r       <= {DW{1'b0}};
            avg_r        <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
                        sum_r    <= sum_next_s;
                        if (!full_s) begin
                            count_r <= count_r + CW'(1);
                        end
                        if (full_s || (count_r == CW'(DEPTH - 1))) begin
                            ready_r   <= 1'b1;
                            state_r   <= ST_DIV;
                            quo_r     <= div_in_s;
                            rem_r     <= {AW{1'b0}};
                            div_cnt_r <= {DCW{1'b0}};
                        end
                    end
                end
                ST_DIV: begin
                    quo_r <= {quo_r[SW-2:0], qbit_s};
                    rem_r <= rem_next_s;
                    if (div_cnt_r == DCW'(SW - 1)) begin
                        state_r     <= ST_SCAN;
                        scan_idx_r  <= {AW{1'b0}};
                        best_dist_r <= {DW{1'b1}};
                    end else begin
                        div_cnt_r <= div_cnt_r + DCW'(1);
                    end
                end
                ST_SCAN: begin
                    best_val_r  <= new_best_val_s;
                    best_dist_r <= new_best_dist_s;
                    if (scan_idx_r == AW'(DEPTH - 1)) begin
                        dout_r       <= new_best_val_s;
                        avg_r        <= avg_s;
                        dout_valid_r <= 1'b1;
                        state_r      <= ST_OUT;
                    end else begin
                        scan_idx_r <= scan_idx_r + AW'(1);
                    end
                end
                ST_OUT: begin
                    dout_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.din_ready  = (state_r == ST_IDLE);
    assign bus.ready      = ready_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout       = dout_r;
    assign bus.avg_out    = avg_r;
endmodule

// File: tb/tb_avg_nearest_win.sv
// Scoreboard bench for avg_nearest_win: the stimulus side pushes the expected
// result (value, mean, arrival cycle) for every accept that completes a full
// window; a monitor pops and compares on each dout_valid pulse.
module tb_avg_nearest_win;
    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int SW    = 20;
    localparam int LAT   = SW + DEPTH;   // edges from accept edge to dout_valid

    typedef struct {
        int dout;
        int avg;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    avg_nearest_win_if #(.DW(DW)) bus ();

    avg_nearest_win #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   window[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   accepts   = 0;
    int   sends     = 0;
    int   last_dout = -1;
    int   last_avg  = -1;
    logic prev_dv   = 1'b0;
    exp_t mon_e;

    function automatic void check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference model: floor or rounded mean, nearest sample, ties to lower.
    function automatic void model_push(int v);
        int sum, mean, bv, bd, d;
        window.push_back(v);
        if (window.size() > DEPTH) void'(window.pop_front());
        if (window.size() == DEPTH) begin
            sum = 0;
            foreach (window[i]) sum += window[i];
`ifdef AVG_ROUND_EN
            mean = (sum + DEPTH / 2) / DEPTH;
`else
            mean = sum / DEPTH;
`endif
            bd = 32'h7fffffff;
            bv = 0;
            foreach (window[i]) begin
                d = (window[i] >= mean) ? window[i] - mean : mean - window[i];
                if (d < bd || (d == bd && window[i] < bv)) begin
                    bd = d;
                    bv = window[i];
                end
            end
            exp_q.push_back('{dout: bv, avg: mean, cyc: cyc + 1 + LAT});
        end
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.din_valid && bus.din_ready) accepts <= accepts + 1;
    end

    // Monitor: compare every result pulse against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_dv = 1'b0;
        end else begin
            if (bus.dout_valid) begin
                check("dout_valid_single_cycle", int'(prev_dv), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got dout=%0d avg=%0d, no result expected (cycle %0d)",
                             bus.dout, bus.avg_out, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout", int'(bus.dout), mon_e.dout);
                    check("avg_out", int'(bus.avg_out), mon_e.avg);
                    check("latency_cycle", cyc, mon_e.cyc);
                end
                last_dout = int'(bus.dout);
                last_avg  = int'(bus.avg_out);
            end
            prev_dv = bus.dout_valid;
        end
    end

    // Present a sample (called at a negedge) and hold it until accepted.
    task automatic send(input int v);
        int budget;
        bus.din       = DW'(v);
        bus.din_valid = 1'b1;
        budget = 0;
        while (!bus.din_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.din_ready) begin
            check("din_ready_timeout", 0, 1);
        end else begin
            model_push(v);
            sends++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.din_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending_results", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int exp_a1, exp_a2;

    initial begin
`ifdef AVG_ROUND_EN
        exp_a1 = 7;
        exp_a2 = 8;
`else
        exp_a1 = 6;
        exp_a2 = 7;
`endif
        reset         = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(bus.ready), 0);
        check("reset_dout_valid", int'(bus.dout_valid), 0);
        check("reset_dout", int'(bus.dout), 0);
        check("reset_avg_out", int'(bus.avg_out), 0);
        check("reset_din_ready", int'(bus.din_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Fill 1..12: only the 12th accept produces a result.
        for (int i = 1; i <= 11; i++) send(i);
        check("ready_during_fill", int'(bus.ready), 0);
        send(12);
        check("ready_after_fill", int'(bus.ready), 1);
        check("din_ready_in_div", int'(bus.din_ready), 0);
        idle();
        drain();
        check("ramp_dout", last_dout, exp_a1);
        check("ramp_avg", last_avg, exp_a1);

        // Window 2..13, sum 90.
        send(13);
        idle();
        drain();
        check("slide_dout", last_dout, exp_a2);
        check("slide_avg", last_avg, exp_a2);

        // Alternating 4/8: mean 6, tie resolves to 4.
        for (int i = 0; i < 12; i++) send((i % 2 == 0) ? 4 : 8);
        idle();
        drain();
        check("tie_dout", last_dout, 4);
        check("tie_avg", last_avg, 6);

        // All-max window.
        for (int i = 0; i < 12; i++) send(16'hFFFF);
        idle();
        drain();
        check("max_dout", last_dout, 65535);
        check("max_avg", last_avg, 65535);

        // din_valid held high with incrementing data.
        for (int v = 100; v <= 104; v++) send(v);
        idle();
        drain();
        check("stream_dout", last_dout, 65535);
        check("stream_avg", last_avg, 38271);
        check("accepts_equal_sends", accepts, sends);

        // Reset while scanning: result discarded, window restarts.
        send(7);
        idle();
        repeat (23) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        window.delete();
        @(negedge clk);
        check("midscan_reset_dout", int'(bus.dout), 0);
        check("midscan_reset_avg", int'(bus.avg_out), 0);
        check("midscan_reset_ready", int'(bus.ready), 0);
        check("midscan_reset_dout_valid", int'(bus.dout_valid), 0);
        check("midscan_reset_din_ready", int'(bus.din_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 11; i++) send(i);
        idle();
        repeat (40) @(negedge clk);
        check("refill_ready_after_11", int'(bus.ready), 0);
        last_dout = -1;
        send(12);
        idle();
        drain();
        check("refill_dout", last_dout, exp_a1);
        check("refill_avg", last_avg, exp_a1);
        check("final_accepts_equal_sends", accepts, sends);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
